// File: rtl/dual_port_mem_if.sv
// Two-port memory bus: port 1 read-only (fetch), port 2 read/write with byte enables (load/store).
// Handshake: a request is taken on a rising edge with req && rdy; rvalid then pulses once with rdata/err.
interface dual_port_mem_if #(
   parameter int DATA_BYTES = 4,
   parameter int ADDR_W     = 32
);
   logic                    p1_req;
   logic [ADDR_W-1:0]       p1_addr;
   logic                    p1_rdy;
   logic                    p1_rvalid;
   logic [8*DATA_BYTES-1:0] p1_rdata;
   logic                    p1_err;

   logic                    p2_req;
   logic                    p2_we;
   logic [DATA_BYTES-1:0]   p2_be;
   logic [ADDR_W-1:0]       p2_addr;
   logic [8*DATA_BYTES-1:0] p2_wdata;
   logic                    p2_rdy;
   logic                    p2_rvalid;
   logic [8*DATA_BYTES-1:0] p2_rdata;
   logic                    p2_err;

   modport master (
      output p1_req, p1_addr,
      input  p1_rdy, p1_rvalid, p1_rdata, p1_err,
      output p2_req, p2_we, p2_be, p2_addr, p2_wdata,
      input  p2_rdy, p2_rvalid, p2_rdata, p2_err
   );

   modport slave (
      input  p1_req, p1_addr,
      output p1_rdy, p1_rvalid, p1_rdata, p1_err,
      input  p2_req, p2_we, p2_be, p2_addr, p2_wdata,
      output p2_rdy, p2_rvalid, p2_rdata, p2_err
   );
endinterface

// File: rtl/dual_port_mem.sv
// Row-organised little-endian two-port memory with per-port IDLE/BEAT2 FSMs.
// DUAL_PORT_MEM_MISALIGN_EN compiles in two-beat misaligned access; otherwise misaligned accesses error.
module dual_port_mem #(
   parameter int DATA_BYTES = 4,
   parameter int MEM_BYTES  = 4096,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   dual_port_mem_if.slave    bus,
   output logic              p1_dbg_state,
   output logic              p2_dbg_state
);
   localparam int DW    = 8 * DATA_BYTES;
   localparam int OFF_W = $clog2(DATA_BYTES);
   localparam int ROWS  = MEM_BYTES / DATA_BYTES;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(DATA_BYTES - 1);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

   typedef enum logic {IDLE = 1'b0, BEAT2 = 1'b1} state_t;

   logic [DW-1:0] mem [ROWS];

   state_t            p1_state;
   state_t            p2_state;
   logic [OFF_W-1:0]  p1_off;
   logic [OFF_W-1:0]  p2_off;
   logic [RW-1:0]     p1_row;
   logic [RW-1:0]     p2_row;
   logic              p1_oob;
   logic              p2_oob;
   logic              p1_mis;
   logic              p2_mis;
   logic              p1_bad;
   logic              p2_bad;

   logic              wr_en;
   logic [RW-1:0]     wr_row;
   logic [DATA_BYTES-1:0] wr_be;
   logic [DW-1:0]     wr_data;

   assign p1_off = bus.p1_addr[OFF_W-1:0];
   assign p2_off = bus.p2_addr[OFF_W-1:0];
   assign p1_row = bus.p1_addr[OFF_W +: RW];
   assign p2_row = bus.p2_addr[OFF_W +: RW];

   // Computed one bit wide so an address near the top of ADDR_W cannot wrap into range.
   assign p1_oob = ({1'b0, bus.p1_addr} + SPAN) >= LIMIT;
   assign p2_oob = ({1'b0, bus.p2_addr} + SPAN) >= LIMIT;
   assign p1_mis = |p1_off;
   assign p2_mis = |p2_off;

`ifdef DUAL_PORT_MEM_MISALIGN_EN
   assign p1_bad = p1_oob;
   assign p2_bad = p2_oob;

   logic [DW-1:0]         p1_part;
   logic [RW-1:0]         p1_nrow;
   logic [OFF_W-1:0]      p1_soff;
   logic [DW-1:0]         p2_part;
   logic [RW-1:0]         p2_nrow;
   logic [OFF_W-1:0]      p2_soff;
   logic                  p2_swe;
   logic [DATA_BYTES-1:0] p2_sbe;
   logic [DW-1:0]         p2_swd;
`else
   assign p1_bad   = p1_oob | p1_mis;
   assign p2_bad   = p2_oob | p2_mis;
   assign p1_state = IDLE;
   assign p2_state = IDLE;
`endif

   assign bus.p1_rdy = (p1_state == IDLE);
   assign bus.p2_rdy = (p2_state == IDLE);
   assign p1_dbg_state = p1_state;
   assign p2_dbg_state = p2_state;

   // Port 1: read-only fetch port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.p1_rvalid <= 1'b0;
         bus.p1_rdata  <= '0;
         bus.p1_err    <= 1'b0;
`ifdef DUAL_PORT_MEM_MISALIGN_EN
         p1_state <= IDLE;
         p1_part  <= '0;
         p1_nrow  <= '0;
         p1_soff  <= '0;
`endif
      end else begin
         bus.p1_rvalid <= 1'b0;
`ifdef DUAL_PORT_MEM_MISALIGN_EN
         if (p1_state == BEAT2) begin
            bus.p1_rvalid <= 1'b1;
            bus.p1_err    <= 1'b0;
            bus.p1_rdata  <= p1_part | (mem[p1_nrow] << (8 * (DATA_BYTES - int'(p1_soff))));
            p1_state      <= IDLE;
         end else
`endif
         if (bus.p1_req) begin
            if (p1_bad) begin
               bus.p1_rvalid <= 1'b1;
               bus.p1_rdata  <= '0;
               bus.p1_err    <= 1'b1;
            end
`ifdef DUAL_PORT_MEM_MISALIGN_EN
            else if (p1_mis) begin
               p1_part  <= mem[p1_row] >> {p1_off, 3'b000};
               p1_nrow  <= p1_row + RW'(1);
               p1_soff  <= p1_off;
               p1_state <= BEAT2;
            end
`endif
            else begin
               bus.p1_rvalid <= 1'b1;
               bus.p1_rdata  <= mem[p1_row];
               bus.p1_err    <= 1'b0;
            end
         end
      end
   end

   // Port 2: load/store port; write responses carry rdata = 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.p2_rvalid <= 1'b0;
         bus.p2_rdata  <= '0;
         bus.p2_err    <= 1'b0;
`ifdef DUAL_PORT_MEM_MISALIGN_EN
         p2_state <= IDLE;
         p2_part  <= '0;
         p2_nrow  <= '0;
         p2_soff  <= '0;
         p2_swe   <= 1'b0;
         p2_sbe   <= '0;
         p2_swd   <= '0;
`endif
      end else begin
         bus.p2_rvalid <= 1'b0;
`ifdef DUAL_PORT_MEM_MISALIGN_EN
         if (p2_state == BEAT2) begin
            bus.p2_rvalid <= 1'b1;
            bus.p2_err    <= 1'b0;
            bus.p2_rdata  <= p2_swe ? '0
                           : (p2_part | (mem[p2_nrow] << (8 * (DATA_BYTES - int'(p2_soff)))));
            p2_state      <= IDLE;
         end else
`endif
         if (bus.p2_req) begin
            if (p2_bad) begin
               bus.p2_rvalid <= 1'b1;
               bus.p2_rdata  <= '0;
               bus.p2_err    <= 1'b1;
            end
`ifdef DUAL_PORT_MEM_MISALIGN_EN
            else if (p2_mis) begin
               // Upper bytes of the request spill into the next row; keep them for beat 2.
               p2_part  <= mem[p2_row] >> {p2_off, 3'b000};
               p2_nrow  <= p2_row + RW'(1);
               p2_soff  <= p2_off;
               p2_swe   <= bus.p2_we;
               p2_sbe   <= bus.p2_be >> (DATA_BYTES - int'(p2_off));
               p2_swd   <= bus.p2_wdata >> (8 * (DATA_BYTES - int'(p2_off)));
               p2_state <= BEAT2;
            end
`endif
            else begin
               bus.p2_rvalid <= 1'b1;
               bus.p2_rdata  <= bus.p2_we ? '0 : mem[p2_row];
               bus.p2_err    <= 1'b0;
            end
         end
      end
   end

   // Single write port: beat 2 of a split write, or a new accepted write (never both).
   always_comb begin
      wr_en   = 1'b0;
      wr_row  = p2_row;
      wr_be   = '0;
      wr_data = '0;
      if (!rst) begin
`ifdef DUAL_PORT_MEM_MISALIGN_EN
         if (p2_state == BEAT2) begin
            wr_en   = p2_swe;
            wr_row  = p2_nrow;
            wr_be   = p2_sbe;
            wr_data = p2_swd;
         end else
`endif
         if (bus.p2_req && bus.p2_we && !p2_bad) begin
            wr_en   = 1'b1;
            wr_row  = p2_row;
            wr_be   = bus.p2_be << p2_off;
            wr_data = bus.p2_wdata << {p2_off, 3'b000};
         end
      end
   end

   // Storage is deliberately not reset; reads above sample it before this edge's write.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < DATA_BYTES; i++) begin
            if (wr_be[i]) begin
               mem[wr_row][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_dual_port_mem.sv
// Directed bench for dual_port_mem: vector table of single accesses plus hand-written multi-cycle sequences.
// Expectations follow DUAL_PORT_MEM_MISALIGN_EN when it is defined for the build.
module tb_dual_port_mem;
   localparam int DB = 4;
   localparam int MB = 4096;
   localparam int AW = 32;
   localparam int DW = 8 * DB;
`ifdef DUAL_PORT_MEM_MISALIGN_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   typedef struct {
      bit            port;
      bit            we;
      logic [DB-1:0] be;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      bit            exp_err;
      int            exp_lat;
   } vec_t;

   localparam int NV = 23;
   vec_t vec [NV];

   logic clk = 1'b0;
   logic rst;
   logic p1_dbg_state;
   logic p2_dbg_state;
   int   checks = 0;
   int   errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_err_q[$];

   dual_port_mem_if #(.DATA_BYTES(DB), .ADDR_W(AW)) bus ();

   dual_port_mem #(.DATA_BYTES(DB), .MEM_BYTES(MB), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .p1_dbg_state (p1_dbg_state),
      .p2_dbg_state (p2_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input bit port, input bit we, input logic [DB-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output logic [DW-1:0] rdata, output logic err, output int lat);
      int guard = 0;
      while ((port ? bus.p2_rdy : bus.p1_rdy) !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      if (port) begin
         bus.p2_req = 1'b1; bus.p2_we = we; bus.p2_be = be;
         bus.p2_addr = addr; bus.p2_wdata = wdata;
      end else begin
         bus.p1_req = 1'b1; bus.p1_addr = addr;
      end
      step();
      bus.p1_req = 1'b0;
      bus.p2_req = 1'b0;
      lat = 1;
      while ((port ? bus.p2_rvalid : bus.p1_rvalid) !== 1'b1 && lat < 8) begin
         step();
         lat++;
      end
      rdata = port ? bus.p2_rdata : bus.p1_rdata;
      err   = port ? bus.p2_err : bus.p1_err;
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic          er;
      int            lat;

      vec[0]  = '{1'b1, 1'b1, 4'hF,    32'h100,  32'hDEADBEEF, 32'h0,        1'b0, 1};
      vec[1]  = '{1'b0, 1'b0, 4'h0,    32'h100,  32'h0,        32'hDEADBEEF, 1'b0, 1};
      vec[2]  = '{1'b1, 1'b0, 4'h0,    32'h100,  32'h0,        32'hDEADBEEF, 1'b0, 1};
      vec[3]  = '{1'b1, 1'b1, 4'b0101, 32'h100,  32'h11223344, 32'h0,        1'b0, 1};
      vec[4]  = '{1'b0, 1'b0, 4'h0,    32'h100,  32'h0,        32'hDE22BE44, 1'b0, 1};
      vec[5]  = '{1'b1, 1'b1, 4'hF,    32'h200,  32'h03020100, 32'h0,        1'b0, 1};
      vec[6]  = '{1'b1, 1'b1, 4'hF,    32'h204,  32'h07060504, 32'h0,        1'b0, 1};
      vec[7]  = '{1'b1, 1'b1, 4'hF,    32'h208,  32'h0B0A0908, 32'h0,        1'b0, 1};
      vec[8]  = '{1'b1, 1'b0, 4'h0,    32'h204,  32'h0,        32'h07060504, 1'b0, 1};
      vec[9]  = '{1'b0, 1'b0, 4'h0,    32'h203,  32'h0,        MIS ? 32'h06050403 : 32'h0, !MIS, MIS ? 2 : 1};
      vec[10] = '{1'b1, 1'b0, 4'h0,    32'h201,  32'h0,        MIS ? 32'h04030201 : 32'h0, !MIS, MIS ? 2 : 1};
      vec[11] = '{1'b1, 1'b1, 4'b1011, 32'h206,  32'hA5B6C7D8, 32'h0,        !MIS, MIS ? 2 : 1};
      vec[12] = '{1'b0, 1'b0, 4'h0,    32'h204,  32'h0,        MIS ? 32'hC7D80504 : 32'h07060504, 1'b0, 1};
      vec[13] = '{1'b0, 1'b0, 4'h0,    32'h208,  32'h0,        MIS ? 32'h0B0AA508 : 32'h0B0A0908, 1'b0, 1};
      vec[14] = '{1'b1, 1'b0, 4'h0,    32'h207,  32'h0,        MIS ? 32'h0AA508C7 : 32'h0, !MIS, MIS ? 2 : 1};
      vec[15] = '{1'b1, 1'b1, 4'hF,    32'h000,  32'hCAFEF00D, 32'h0,        1'b0, 1};
      vec[16] = '{1'b1, 1'b1, 4'hF,    32'h1000, 32'hBADBADBA, 32'h0,        1'b1, 1};
      vec[17] = '{1'b1, 1'b1, 4'hF,    32'hFFC,  32'h12345678, 32'h0,        1'b0, 1};
      vec[18] = '{1'b1, 1'b1, 4'hF,    32'hFFE,  32'h99999999, 32'h0,        1'b1, 1};
      vec[19] = '{1'b0, 1'b0, 4'h0,    32'hFFD,  32'h0,        32'h0,        1'b1, 1};
      vec[20] = '{1'b0, 1'b0, 4'h0,    32'h000,  32'h0,        32'hCAFEF00D, 1'b0, 1};
      vec[21] = '{1'b0, 1'b0, 4'h0,    32'hFFC,  32'h0,        32'h12345678, 1'b0, 1};
      vec[22] = '{1'b1, 1'b0, 4'h0,    32'hFFF,  32'h0,        32'h0,        1'b1, 1};

      // Clock/reset
      rst = 1'b1;
      bus.p1_req = 1'b0; bus.p1_addr = '0;
      bus.p2_req = 1'b0; bus.p2_we = 1'b0; bus.p2_be = '0; bus.p2_addr = '0; bus.p2_wdata = '0;
      repeat (2) step();
      check("reset_p1_rdy", DW'(bus.p1_rdy), 1);
      check("reset_p2_rdy", DW'(bus.p2_rdy), 1);
      check("reset_p1_rvalid", DW'(bus.p1_rvalid), 0);
      check("reset_p2_rvalid", DW'(bus.p2_rvalid), 0);
      check("reset_p1_rdata", bus.p1_rdata, 0);
      check("reset_p2_err", DW'(bus.p2_err), 0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Table-driven single accesses
      for (int i = 0; i < NV; i++) begin
         exp_q.push_back(vec[i].exp_rdata);
         exp_err_q.push_back(DW'(vec[i].exp_err));
         access(vec[i].port, vec[i].we, vec[i].be, vec[i].addr, vec[i].wdata, rd, er, lat);
         check($sformatf("v%0d_rdata", i), rd, exp_q.pop_front());
         check($sformatf("v%0d_err", i), DW'(er), exp_err_q.pop_front());
         check($sformatf("v%0d_latency", i), DW'(lat), DW'(vec[i].exp_lat));
         step();
         check($sformatf("v%0d_pulse", i), DW'(vec[i].port ? bus.p2_rvalid : bus.p1_rvalid), 0);
      end

      // Back-to-back aligned reads on port 1
      bus.p1_req = 1'b1; bus.p1_addr = 32'h100;
      step();
      check("b2b_first_rvalid", DW'(bus.p1_rvalid), 1);
      check("b2b_first_rdata", bus.p1_rdata, 32'hDE22BE44);
      check("b2b_rdy", DW'(bus.p1_rdy), 1);
      bus.p1_addr = 32'h000;
      step();
      bus.p1_req = 1'b0;
      check("b2b_second_rvalid", DW'(bus.p1_rvalid), 1);
      check("b2b_second_rdata", bus.p1_rdata, 32'hCAFEF00D);
      step();

      // Misaligned read: rdy drop and re-accept on the response edge with req held
      bus.p1_req = 1'b1; bus.p1_addr = 32'h203;
      step();
`ifdef DUAL_PORT_MEM_MISALIGN_EN
      bus.p1_addr = 32'h100;
      check("mis_rdy_low", DW'(bus.p1_rdy), 0);
      check("mis_beat2_state", DW'(p1_dbg_state), 1);
      check("mis_no_early_rvalid", DW'(bus.p1_rvalid), 0);
      step();
      check("mis_rvalid", DW'(bus.p1_rvalid), 1);
      check("mis_rdata", bus.p1_rdata, 32'h06050403);
      check("mis_rdy_back", DW'(bus.p1_rdy), 1);
      step();
      bus.p1_req = 1'b0;
      check("mis_next_rvalid", DW'(bus.p1_rvalid), 1);
      check("mis_next_rdata", bus.p1_rdata, 32'hDE22BE44);
`else
      bus.p1_req = 1'b0;
      check("mis_rdy_high", DW'(bus.p1_rdy), 1);
      check("mis_idle_state", DW'(p1_dbg_state), 0);
      check("mis_err_rvalid", DW'(bus.p1_rvalid), 1);
      check("mis_err", DW'(bus.p1_err), 1);
      check("mis_err_rdata", bus.p1_rdata, 0);
`endif
      step();

      // Same-cycle write/read collision returns pre-write data
      access(1'b1, 1'b1, 4'hF, 32'h300, 32'h55555555, rd, er, lat);
      step();
      bus.p1_req = 1'b1; bus.p1_addr = 32'h300;
      bus.p2_req = 1'b1; bus.p2_we = 1'b1; bus.p2_be = 4'hF;
      bus.p2_addr = 32'h300; bus.p2_wdata = 32'hAAAAAAAA;
      step();
      bus.p1_req = 1'b0; bus.p2_req = 1'b0;
      check("coll_p1_rvalid", DW'(bus.p1_rvalid), 1);
      check("coll_p1_old_data", bus.p1_rdata, 32'h55555555);
      check("coll_p2_rvalid", DW'(bus.p2_rvalid), 1);
      step();
      access(1'b0, 1'b0, 4'h0, 32'h300, 32'h0, rd, er, lat);
      check("coll_new_data", rd, 32'hAAAAAAAA);
      step();

`ifdef DUAL_PORT_MEM_MISALIGN_EN
      // Reset while a split write sits in BEAT2
      access(1'b1, 1'b1, 4'hF, 32'h200, 32'h03020100, rd, er, lat);
      access(1'b1, 1'b1, 4'hF, 32'h204, 32'h07060504, rd, er, lat);
      step();
      bus.p2_req = 1'b1; bus.p2_we = 1'b1; bus.p2_be = 4'hF;
      bus.p2_addr = 32'h202; bus.p2_wdata = 32'hA1B2C3D4;
      step();
      bus.p2_req = 1'b0;
      check("rstb2_in_beat2", DW'(p2_dbg_state), 1);
      rst = 1'b1;
      #1;
      check("rstb2_rdy", DW'(bus.p2_rdy), 1);
      step();
      check("rstb2_no_rvalid", DW'(bus.p2_rvalid), 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check("rstb2_no_late_rvalid", DW'(bus.p2_rvalid), 0);
      access(1'b0, 1'b0, 4'h0, 32'h200, 32'h0, rd, er, lat);
      check("rstb2_row_r_kept", rd, 32'hC3D40100);
      access(1'b0, 1'b0, 4'h0, 32'h204, 32'h0, rd, er, lat);
      check("rstb2_row_r1_dropped", rd, 32'h07060504);
      step();
`endif

      // Asynchronous reset mid-cycle clears live outputs without a clock edge
      bus.p1_req = 1'b1; bus.p1_addr = 32'h100;
      step();
      bus.p1_req = 1'b0;
      check("async_pre_rvalid", DW'(bus.p1_rvalid), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rvalid", DW'(bus.p1_rvalid), 0);
      check("async_rdata", bus.p1_rdata, 0);
      check("async_err", DW'(bus.p1_err), 0);
      check("async_rdy", DW'(bus.p1_rdy), 1);
      @(negedge clk);
      rst = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
